// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: RV32I opcode constants, ALU encodings, FSM and decoded-record types
package decode_stage_pkg;
  localparam logic [31:0] NOP_WORD_DEF = 32'h00000013;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;
  typedef enum logic {RUN, HOLD} state_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_t     alu_op;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        reg_write;
    logic        illegal;
  } dec_t;
  // Only register-register ops use funct7[5] to select SUB; shifts use it in both forms
  function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt, input logic reg_op);
    case (f3)
      3'b000:  return (alt && reg_op) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate extractor (I/S/B/U/J, R-type and unknown give 0)
module imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] imm
);
  logic [6:0] op;
  assign op = word[6:0];
  assign imm = (op == OPC_OP_IMM || op == OPC_LOAD || op == OPC_JALR) ? {{20{word[31]}}, word[31:20]} :
               op == OPC_STORE  ? {{20{word[31]}}, word[31:25], word[11:7]} :
               op == OPC_BRANCH ? {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0} :
               (op == OPC_LUI || op == OPC_AUIPC) ? {word[31:12], 12'b0} :
               op == OPC_JAL    ? {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0} : '0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder with load-use stall, hold register and jump flush
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] opcode,
  input  logic [31:0] pc_in,
  input  logic        jump,
  output logic        valid,
  output logic [31:0] pc_out,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [3:0]  alu_op,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        reg_write,
  output logic        stall_req,
  output logic        illegal
);
  state_t state, state_nx;
  dec_t q, d;
  logic [31:0] hold_word, hold_pc, word, imm_w;
  logic [6:0] op, in_op;
  logic bubble, reads1, reads2, hit;
  assign in_op = opcode[6:0];
  assign reads1 = in_op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
  assign reads2 = in_op inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  // A bubble already in the stage has valid=0, so it can never raise a second stall
  assign hit = q.valid && q.is_load && q.rd != '0;
  assign stall_req = state == RUN && !jump && hit &&
                     ((reads1 && opcode[19:15] == q.rd) || (reads2 && opcode[24:20] == q.rd));
  assign bubble = jump || stall_req;
  assign word = bubble ? NOP_WORD : state == HOLD ? hold_word : opcode;
  assign op = word[6:0];
  imm_gen u_imm_gen (
    .word (word),
    .imm  (imm_w)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else if (en) state <= state_nx;
  always_comb state_nx = stall_req ? HOLD : RUN;
  always_comb begin
    d = '0;
    d.rs1 = word[19:15];
    d.rs2 = word[24:20];
    d.rd = word[11:7];
    d.imm = imm_w;
    d.alu_op = op == OPC_OP ? alu_sel(word[14:12], word[30], 1'b1) :
               op == OPC_OP_IMM ? alu_sel(word[14:12], word[30], 1'b0) :
               op == OPC_LUI ? ALU_PASS_B : ALU_ADD;
    if (!bubble) begin
      d.valid = 1'b1;
      d.pc = state == HOLD ? hold_pc : pc_in;
      d.is_load = op == OPC_LOAD;
      d.is_store = op == OPC_STORE;
      d.is_branch = op == OPC_BRANCH;
      d.is_jal = op == OPC_JAL;
      d.is_jalr = op == OPC_JALR;
      d.reg_write = d.rd != '0 && op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
      d.illegal = !(op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI,
                               OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_FENCE, OPC_SYSTEM});
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '0;
      hold_word <= '0;
      hold_pc <= '0;
    end else if (en) begin
      q <= d;
      hold_word <= stall_req ? opcode : '0;
      hold_pc <= stall_req ? pc_in : '0;
    end
  assign valid = q.valid;
  assign pc_out = q.pc;
  assign rs1 = q.rs1;
  assign rs2 = q.rs2;
  assign rd = q.rd;
  assign imm = q.imm;
  assign alu_op = q.alu_op;
  assign is_load = q.is_load;
  assign is_store = q.is_store;
  assign is_branch = q.is_branch;
  assign is_jal = q.is_jal;
  assign is_jalr = q.is_jalr;
  assign reg_write = q.reg_write;
  assign illegal = q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table plus stall, flush, enable and reset sequences
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst, en, jump;
  logic [31:0] opcode, pc_in;
  logic valid, is_load, is_store, is_branch, is_jal, is_jalr, reg_write, stall_req, illegal;
  logic [31:0] pc_out, imm;
  logic [4:0] rs1, rs2, rd;
  logic [3:0] alu_op;
  logic [5:0] fl;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign fl = {is_load, is_store, is_branch, is_jal, is_jalr, reg_write};
  decode_stage dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .pc_in(pc_in), .jump(jump),
    .valid(valid), .pc_out(pc_out), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .alu_op(alu_op), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .reg_write(reg_write), .stall_req(stall_req),
    .illegal(illegal)
  );
  typedef struct {
    logic [31:0] op;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [5:0]  fl;
    logic        ill;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{32'h00500093, 32'h04, 5'd0, 5'd5,  5'd1,  32'h00000005, 4'd0,  6'b000001, 1'b0};
    v[1]  = '{32'h800002B7, 32'h08, 5'd0, 5'd0,  5'd5,  32'h80000000, 4'd10, 6'b000001, 1'b0};
    v[2]  = '{32'hFFFFFFFF, 32'h0C, 5'd31, 5'd31, 5'd31, 32'h00000000, 4'd0, 6'b000000, 1'b1};
    v[3]  = '{32'h0020A423, 32'h10, 5'd1, 5'd2,  5'd8,  32'h00000008, 4'd0,  6'b010000, 1'b0};
    v[4]  = '{32'hFE208EE3, 32'h14, 5'd1, 5'd2,  5'd29, 32'hFFFFFFFC, 4'd0,  6'b001000, 1'b0};
    v[5]  = '{32'h001000EF, 32'h18, 5'd0, 5'd1,  5'd1,  32'h00000800, 4'd0,  6'b000101, 1'b0};
    v[6]  = '{32'h00008067, 32'h1C, 5'd1, 5'd0,  5'd0,  32'h00000000, 4'd0,  6'b000010, 1'b0};
    v[7]  = '{32'h402081B3, 32'h20, 5'd1, 5'd2,  5'd3,  32'h00000000, 4'd1,  6'b000001, 1'b0};
    v[8]  = '{32'h4030D213, 32'h24, 5'd1, 5'd3,  5'd4,  32'h00000403, 4'd7,  6'b000001, 1'b0};
    v[9]  = '{32'hFFF02303, 32'h28, 5'd0, 5'd31, 5'd6,  32'hFFFFFFFF, 4'd0,  6'b100001, 1'b0};
    v[10] = '{32'h12345397, 32'h2C, 5'd8, 5'd3,  5'd7,  32'h12345000, 4'd0,  6'b000001, 1'b0};
    v[11] = '{32'h00208033, 32'h30, 5'd1, 5'd2,  5'd0,  32'h00000000, 4'd0,  6'b000000, 1'b0};
    rst = 1'b0;
    en = 1'b1;
    jump = 1'b0;
    opcode = 32'h0;
    pc_in = 32'h0;
    #12;
    chk("rst.valid", valid, 0);
    chk("rst.pc", pc_out, 0);
    chk("rst.flags", fl, 0);
    chk("rst.illegal", illegal, 0);
    chk("rst.stall", stall_req, 0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      opcode = v[i].op;
      pc_in = v[i].pc;
      tick();
      chk($sformatf("v%0d.valid", i), valid, 1);
      chk($sformatf("v%0d.pc", i), pc_out, v[i].pc);
      chk($sformatf("v%0d.rs1", i), rs1, v[i].rs1);
      chk($sformatf("v%0d.rs2", i), rs2, v[i].rs2);
      chk($sformatf("v%0d.rd", i), rd, v[i].rd);
      chk($sformatf("v%0d.imm", i), imm, v[i].imm);
      chk($sformatf("v%0d.alu", i), alu_op, v[i].alu);
      chk($sformatf("v%0d.flags", i), fl, v[i].fl);
      chk($sformatf("v%0d.illegal", i), illegal, v[i].ill);
    end
    // load-use: lw x2,0(x1) then add x3,x2,x2
    opcode = 32'h0000A103; pc_in = 32'h100;
    tick();
    chk("lu.load", is_load, 1);
    opcode = 32'h002101B3; pc_in = 32'h104;
    #1 chk("lu.stall", stall_req, 1);
    tick();
    chk("lu.bubble", valid, 0);
    chk("lu.bubble_rw", reg_write, 0);
    chk("lu.no_restall", stall_req, 0);
    opcode = 32'h00100493; pc_in = 32'h108;
    #1 chk("lu.hold_stall", stall_req, 0);
    tick();
    chk("lu.add_valid", valid, 1);
    chk("lu.add_pc", pc_out, 32'h104);
    chk("lu.add_rd", rd, 3);
    chk("lu.add_rs1", rs1, 2);
    tick();
    chk("lu.next_pc", pc_out, 32'h108);
    chk("lu.next_rd", rd, 9);
    // jump overrides a pending hazard
    opcode = 32'h0000A103; pc_in = 32'h200;
    tick();
    opcode = 32'h002101B3; pc_in = 32'h204; jump = 1'b1;
    #1 chk("jmp.stall", stall_req, 0);
    tick();
    jump = 1'b0;
    chk("jmp.valid", valid, 0);
    chk("jmp.flags", fl, 0);
    opcode = 32'hFE208EE3; pc_in = 32'h208;
    tick();
    chk("jmp.beq", is_branch, 1);
    opcode = 32'h00100493; pc_in = 32'h20C; jump = 1'b1;
    tick();
    jump = 1'b0;
    chk("jmp.beq_valid", valid, 0);
    chk("jmp.beq_flags", fl, 0);
    opcode = 32'h00100493; pc_in = 32'h210;
    tick();
    chk("jmp.resume_valid", valid, 1);
    chk("jmp.resume_pc", pc_out, 32'h210);
    // enable low freezes everything
    opcode = 32'h00500093; pc_in = 32'h300;
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      opcode = 32'h402081B3 + i; pc_in = 32'h400 + 4 * i;
      tick();
      chk($sformatf("en%0d.pc", i), pc_out, 32'h300);
      chk($sformatf("en%0d.rd", i), rd, 1);
      chk($sformatf("en%0d.imm", i), imm, 5);
    end
    en = 1'b1; opcode = 32'h00100493; pc_in = 32'h500;
    tick();
    chk("en.resume_pc", pc_out, 32'h500);
    chk("en.resume_rd", rd, 9);
    // reset while holding a stalled word
    opcode = 32'h0000A103; pc_in = 32'h600;
    tick();
    opcode = 32'h002101B3; pc_in = 32'h604; en = 1'b0;
    #1 chk("hr.stall_en0", stall_req, 1);
    tick();
    chk("hr.frozen_pc", pc_out, 32'h600);
    en = 1'b1;
    tick();
    chk("hr.bubble", valid, 0);
    #2 rst = 1'b0;
    #1;
    chk("hr.rst_valid", valid, 0);
    chk("hr.rst_pc", pc_out, 0);
    opcode = 32'h00100493; pc_in = 32'h700;
    #2 rst = 1'b1;
    tick();
    chk("hr.after_valid", valid, 1);
    chk("hr.after_pc", pc_out, 32'h700);
    chk("hr.after_rd", rd, 9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter NOP_WORD, 32'h00000013, instruction word substituted for bubbles (addi x0,x0,0).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  stage enable; low freezes all registers (same gate as fetch en).
REQ-005 opcode  input  32  instruction word from fetch.
REQ-006 pc_in  input  32  PC of opcode, zero-extended from fetch.
REQ-007 jump  input  1  flush request from execute; current and incoming words are discarded.
REQ-008 valid  output  1  decoded outputs hold a real instruction.
REQ-009 pc_out  output  32  PC of decoded instruction.
REQ-010 rs1, rs2, rd  output  5 each  register addresses.
REQ-011 imm  output  32  sign-extended immediate.
REQ-012 alu_op  output  4  ALU operation code (encodings in package).
REQ-013 is_load, is_store, is_branch, is_jal, is_jalr, reg_write  output  1 each  control flags.
REQ-014 stall_req  output  1  combinational; high = fetch must hold (deassert its en).
REQ-015 illegal  output  1  registered; decoded word is not RV32I.

Function
REQ-016 Encoding is RV32I base; immediates decoded for I, S, B, U, J formats, bit 31 sign-extended to 32 bits; R-type imm = 0.
REQ-017 Latency: one clk from opcode/pc_in to registered outputs when en=1, jump=0, stall_req=0.
REQ-018 en=0: every register holds; stall_req still evaluated combinationally.
REQ-019 jump=1 with en=1: next edge loads NOP_WORD, valid=0, reg_write=0, all flags 0; one-cycle bubble.
REQ-020 Load-use hazard: if registered is_load=1, valid=1, rd!=0 and incoming opcode reads rs1 or rs2 equal to rd, stall_req=1.
REQ-021 During stall_req=1 the next edge loads a bubble (valid=0) and latches the incoming opcode/pc_in into an internal hold register; the following cycle decodes from the hold register, not from opcode.
REQ-022 Hold FSM states: RUN, HOLD; RUN->HOLD on stall_req with en=1 and jump=0; HOLD->RUN on next en=1 edge; jump in either state -> RUN with the held word discarded.
REQ-023 jump and stall_req simultaneously: jump wins, bubble inserted, nothing held, stall_req forced 0.
REQ-024 rd=0 never triggers a hazard; reg_write is forced 0 when rd=0.
REQ-025 Unknown major opcode: illegal=1, valid=1, all control flags 0, reg_write=0.
REQ-026 No back-to-back stall: a bubble inserted by REQ-021 (valid=0) cannot cause a second stall.

Reset
REQ-027 rst=0 asynchronously forces valid=0, pc_out=0, instruction register=NOP_WORD, all flags 0, illegal=0, FSM=RUN, hold register cleared.
REQ-028 Reset asserted mid-HOLD discards the held word; first edge after release samples opcode normally.

Structure
REQ-029 Package holds: major opcode constants, alu_op encodings, NOP_WORD default, FSM state typedef.
REQ-030 One sub-module, imm_gen (combinational immediate extractor), instantiated once.
REQ-031 Registered outputs only, except stall_req.

Verification
REQ-032 opcode=32'h00500093 (addi x1,x0,5), pc_in=4 -> next cycle valid=1, rd=1, rs1=0, imm=5, reg_write=1, pc_out=4.
REQ-033 lw x2,0(x1) then add x3,x2,x2 -> stall_req=1 one cycle, one valid=0 bubble, then add decoded with pc_out of add.
REQ-034 jump=1 while beq in stage -> next cycle valid=0, flags 0; stall_req=0 even if hazard present.
REQ-035 en=0 for 3 cycles with changing opcode -> all outputs unchanged; resume decodes word present at re-enable.
REQ-036 rst pulled low in HOLD -> valid=0, pc_out=0 immediately; after release no held word emitted.
REQ-037 opcode=32'hFFFFFFFF -> illegal=1, reg_write=0; lui x5,0x80000 -> imm=32'h80000000.
